// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, LSB first, one bit per clock with start/busy/done handshake
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_count;

    logic             w_s;
    logic             w_c;

    // Same sum / majority-carry equation as the single-bit full adder stage.
    assign w_s = r_sa[0] ^ r_sb[0] ^ r_carry;
    assign w_c = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            busy <= 1'b0;
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_carry <= cin;
                        r_count <= '0;
                        busy    <= 1'b1;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_res   <= {w_s, r_res[WIDTH-1:1]};
                    r_carry <= w_c;
                    r_count <= r_count + CW'(1);
                    if (r_count == LAST) begin
                        sum     <= {w_s, r_res[WIDTH-1:1]};
                        cout    <= w_c;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        busy <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
